seg7_scan: RTL and testbench

Time-multiplexed driver for a DIGITS-digit common-anode 7-segment display. It holds a nibble-per-digit value and scans one digit at a time at a programmable refresh rate. Each digit is decoded in decimal or hex mode, with optional leading-zero blanking and per-digit decimal points. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the datapath (which supplies `data_in` and pulses `load`) and the board pins.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_hexdec.sv | 21 ++
 rtl/seg7_scan.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment codes and nibble decode for the 7-segment scan driver.
// All codes are {g,f,e,d,c,b,a}, active-low (common anode).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  // Nibbles above 9 show a dash unless hex decoding is selected.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib, input logic hex);
    logic [6:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      4'd10:   code = hex ? SEG_A : SEG_DASH;
      4'd11:   code = hex ? SEG_B : SEG_DASH;
      4'd12:   code = hex ? SEG_C : SEG_DASH;
      4'd13:   code = hex ? SEG_D : SEG_DASH;
      4'd14:   code = hex ? SEG_E : SEG_DASH;
      4'd15:   code = hex ? SEG_F : SEG_DASH;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational nibble-to-segment decoder with a blanking override.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_hex,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blanking wins over the decoded glyph.
  always_comb begin
    o_seg = SEG_BLANK;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = seg7_decode(i_nib, i_hex);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned value commit,
// hex/decimal decode, leading-zero blanking and per-digit decimal points.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  pending
);

  localparam int             CW      = $clog2(DIV);
  localparam int             IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_run;
  logic [4*DIGITS-1:0]   r_act_data;
  logic [DIGITS-1:0]     r_act_dp;
  logic [4*DIGITS-1:0]   r_pend_data;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pending;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_dp;

  logic                  w_tick;
  logic                  w_boundary;
  logic [IW-1:0]         w_idx_nxt;
  logic [4*DIGITS-1:0]   w_act_data_nxt;
  logic [DIGITS-1:0]     w_act_dp_nxt;
  logic [3:0]            w_nib;
  logic [DIGITS-1:0]     w_lz;
  logic [DIGITS-1:0]     w_an;
  logic [6:0]            w_seg;

  assign w_tick = (r_cnt == CNT_MAX);
  // The first tick after reset is treated as a boundary so the scan opens on digit 0.
  assign w_boundary = w_tick & (~r_run | (r_idx == IDX_MAX));

  // Next digit index and next active value; a load on the boundary bypasses pending.
  always_comb begin
    w_idx_nxt      = r_idx;
    w_act_data_nxt = r_act_data;
    w_act_dp_nxt   = r_act_dp;
    if (w_boundary) begin
      w_idx_nxt = '0;
    end else if (w_tick) begin
      w_idx_nxt = r_idx + IW'(1);
    end else begin
      w_idx_nxt = r_idx;
    end
    if (w_boundary && load) begin
      w_act_data_nxt = data_in;
      w_act_dp_nxt   = dp_in;
    end else if (w_boundary && r_pending) begin
      w_act_data_nxt = r_pend_data;
      w_act_dp_nxt   = r_pend_dp;
    end else begin
      w_act_data_nxt = r_act_data;
      w_act_dp_nxt   = r_act_dp;
    end
  end

  // Leading-zero mask: digit k blanks when it and every digit above it are zero.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (w_act_data_nxt[4*k +: 4] == 4'd0);
      w_lz[k]    = w_zero_run & (k != 0);
    end
  end

  // One-hot-low anode pattern for the next slot.
  always_comb begin
    w_an = '1;
    for (int k = 0; k < DIGITS; k++) begin
      w_an[k] = (w_idx_nxt != IW'(k));
    end
  end

  assign w_nib = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];

  seg7_hexdec u_hexdec (
    .i_nib   (w_nib),
    .i_hex   (hex_mode),
    .i_blank (blank_lz & w_lz[w_idx_nxt]),
    .o_seg   (w_seg)
  );

  // Prescaler, scan index and the capture/commit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_run       <= 1'b0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pending   <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + CW'(1);
      r_idx      <= w_idx_nxt;
      r_run      <= r_run | w_tick;
      r_act_data <= w_act_data_nxt;
      r_act_dp   <= w_act_dp_nxt;
      if (load) begin
        r_pend_data <= data_in;
        r_pend_dp   <= dp_in;
      end else begin
        r_pend_data <= r_pend_data;
        r_pend_dp   <= r_pend_dp;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // Pin drivers change only on slot edges so a slot never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      r_seg <= w_seg;
      r_an  <= w_an;
      r_dp  <= ~w_act_dp_nxt[w_idx_nxt];
    end else begin
      r_seg <= r_seg;
      r_an  <= r_an;
      r_dp  <= r_dp;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign dp      = r_dp;
  assign pending = r_pending;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with DIGITS=4, DIV=4.
module tb_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        pending;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  seg7_scan #(.DIGITS(4), .DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    chk({tag, "_an"}, {28'd0, an}, {28'd0, e_an});
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
    chk({tag, "_dp"}, {31'd0, dp}, {31'd0, e_dp});
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; data_in = 16'h0000; dp_in = 4'b0000;
    hex_mode = 1'b0; blank_lz = 1'b0;
    #12;
    slot("reset", 4'b1111, 7'b1111111, 1'b1);
    chk("reset_pending", {31'd0, pending}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // scan order after release
    cyc(3);
    chk("no_early_an", {28'd0, an}, 32'h0000000f);
    cyc(1); slot("scan_d0", 4'b1110, 7'b1000000, 1'b1);
    cyc(4); slot("scan_d1", 4'b1101, 7'b1000000, 1'b1);
    cyc(4); slot("scan_d2", 4'b1011, 7'b1000000, 1'b1);
    cyc(4); slot("scan_d3", 4'b0111, 7'b1000000, 1'b1);
    cyc(4); slot("scan_wrap", 4'b1110, 7'b1000000, 1'b1);

    // mid-frame load of 0x1234
    load = 1'b1; data_in = 16'h1234; dp_in = 4'b0000;
    cyc(1); load = 1'b0;
    chk("pend_set", {31'd0, pending}, 32'd1);
    cyc(14);
    chk("pend_hold", {31'd0, pending}, 32'd1);
    cyc(1);
    chk("pend_clr", {31'd0, pending}, 32'd0);
    slot("v1234_d0", 4'b1110, 7'b0011001, 1'b1);
    cyc(4); slot("v1234_d1", 4'b1101, 7'b0110000, 1'b1);
    cyc(4); slot("v1234_d2", 4'b1011, 7'b0100100, 1'b1);
    cyc(4); slot("v1234_d3", 4'b0111, 7'b1111001, 1'b1);

    // hex vs decimal decode of 0xFAAA
    load = 1'b1; data_in = 16'hFAAA;
    cyc(1); load = 1'b0; hex_mode = 1'b1;
    cyc(3); slot("hexA", 4'b1110, 7'b0001000, 1'b1);
    hex_mode = 1'b0;
    cyc(4); slot("decA", 4'b1101, 7'b0111111, 1'b1);
    hex_mode = 1'b1;
    cyc(4); slot("hexA2", 4'b1011, 7'b0001000, 1'b1);
    cyc(4); slot("hexF", 4'b0111, 7'b0001110, 1'b1);
    hex_mode = 1'b0;

    // leading-zero blanking with a dp on a blanked digit
    blank_lz = 1'b1;
    load = 1'b1; data_in = 16'h0045; dp_in = 4'b0100;
    cyc(1); load = 1'b0;
    cyc(3); slot("lz_d0", 4'b1110, 7'b0010010, 1'b1);
    cyc(4); slot("lz_d1", 4'b1101, 7'b0011001, 1'b1);
    cyc(4); slot("lz_d2", 4'b1011, 7'b1111111, 1'b0);
    cyc(4); slot("lz_d3", 4'b0111, 7'b1111111, 1'b1);
    load = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
    cyc(1); load = 1'b0;
    cyc(3); slot("lz0_d0", 4'b1110, 7'b1000000, 1'b1);
    cyc(4); slot("lz0_d1", 4'b1101, 7'b1111111, 1'b1);
    cyc(8); slot("lz0_d3", 4'b0111, 7'b1111111, 1'b1);
    blank_lz = 1'b0;

    // overwrite in-frame, then load exactly on the boundary tick
    load = 1'b1; data_in = 16'h1111;
    cyc(1); data_in = 16'h2222;
    cyc(1); load = 1'b0;
    chk("ovr_pend", {31'd0, pending}, 32'd1);
    cyc(1); load = 1'b1; data_in = 16'h3333;
    cyc(1); load = 1'b0;
    chk("bnd_pend", {31'd0, pending}, 32'd0);
    slot("bnd_d0", 4'b1110, 7'b0110000, 1'b1);
    cyc(4); slot("bnd_d1", 4'b1101, 7'b0110000, 1'b1);

    // asynchronous reset mid-slot with a pending value
    load = 1'b1; data_in = 16'h5678; dp_in = 4'b1111;
    cyc(1); load = 1'b0;
    chk("ar_pend", {31'd0, pending}, 32'd1);
    #2; rst_n = 1'b0;
    #1;
    slot("ar_blank", 4'b1111, 7'b1111111, 1'b1);
    chk("ar_pend_clr", {31'd0, pending}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc(4); slot("ar_d0", 4'b1110, 7'b1000000, 1'b1);
    chk("ar_pend_after", {31'd0, pending}, 32'd0);
    cyc(4); slot("ar_d1", 4'b1101, 7'b1000000, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
